// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, refilled a byte
// at a time from a byte-wide memory port.
module icache #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ic_read,
  input  logic [31:0] ic_addr,
  output logic [31:0] ic_ans,
  output logic        ic_done,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_ans,
  input  logic        mem_done
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:2]   r_addr, w_addr_nxt;
  logic [1:0]    r_cnt, w_cnt_nxt;
  logic [23:0]   r_buf, w_buf_nxt;
  logic [31:0]   r_ans, w_ans_nxt;
  logic          r_done, w_done_nxt;
  logic          r_mrd, w_mrd_nxt;
  logic [31:0]   r_maddr, w_maddr_nxt;

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [LINES];

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_hit;
  logic                  w_we;
  logic [31:0]           w_fill_word;
  logic                  w_unused;

  assign w_unused    = ^ic_addr[1:0];
  assign w_idx       = r_addr[INDEX_BITS+1:2];
  assign w_tag       = r_addr[31:INDEX_BITS+2];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill_word = {mem_ans, r_buf};

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_buf_nxt   = r_buf;
    w_ans_nxt   = r_ans;
    w_done_nxt  = r_done;
    w_mrd_nxt   = r_mrd;
    w_maddr_nxt = r_maddr;
    w_we        = 1'b0;
    if (rdy) begin
      unique case (r_state)
        IDLE: begin
          if (ic_read) begin
            w_addr_nxt  = ic_addr[31:2];
            w_state_nxt = LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            w_ans_nxt   = r_data[w_idx];
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_mrd_nxt   = 1'b1;
            w_maddr_nxt = {r_addr, 2'b00};
            w_cnt_nxt   = '0;
            w_state_nxt = FILL;
          end
        end
        FILL: begin
          if (mem_done) begin
            w_cnt_nxt = r_cnt + 2'd1;
            // The fourth byte bypasses the buffer straight into the line and ic_ans.
            if (r_cnt == 2'd3) begin
              w_we        = 1'b1;
              w_mrd_nxt   = 1'b0;
              w_ans_nxt   = w_fill_word;
              w_done_nxt  = 1'b1;
              w_state_nxt = DONE;
            end else begin
              unique case (r_cnt)
                2'd0:    w_buf_nxt[7:0]   = mem_ans;
                2'd1:    w_buf_nxt[15:8]  = mem_ans;
                default: w_buf_nxt[23:16] = mem_ans;
              endcase
              w_maddr_nxt = r_maddr + 32'd1;
            end
          end
        end
        DONE: begin
          w_done_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_ans   <= '0;
      r_done  <= 1'b0;
      r_mrd   <= 1'b0;
      r_maddr <= '0;
      r_valid <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_buf   <= w_buf_nxt;
      r_ans   <= w_ans_nxt;
      r_done  <= w_done_nxt;
      r_mrd   <= w_mrd_nxt;
      r_maddr <= w_maddr_nxt;
      if (w_we) r_valid[w_idx] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; r_valid alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= w_fill_word;
    end
  end

  assign ic_ans   = r_ans;
  assign ic_done  = r_done;
  assign mem_read = r_mrd;
  assign mem_addr = r_maddr;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: byte-memory responder, reference tag model,
// expected words queued at request time and compared on ic_done.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        ic_read;
  logic [31:0] ic_addr;
  logic [31:0] ic_ans;
  logic        ic_done;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [7:0]  mem_ans;
  logic        mem_done;

  icache #(.INDEX_BITS(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .ic_read  (ic_read),
    .ic_addr  (ic_addr),
    .ic_ans   (ic_ans),
    .ic_done  (ic_done),
    .mem_read (mem_read),
    .mem_addr (mem_addr),
    .mem_ans  (mem_ans),
    .mem_done (mem_done)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  logic [7:0]  mem_model [4096];
  logic [23:0] m_tag     [64];
  bit          m_valid   [64];

  logic [31:0] word_q [$];
  logic [31:0] addr_q [$];

  int unsigned n_bytes  = 0;
  int unsigned lat      = 1;
  bit          resp_en  = 1'b1;
  bit          spurious = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Byte memory: answers mem_read after `lat` idle negedges, one pulse per byte.
  initial begin
    int unsigned lat_cnt;
    logic [31:0] exp_a;
    lat_cnt  = 0;
    mem_done = 1'b0;
    mem_ans  = '0;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      if (spurious) begin
        mem_done = 1'b1;
        mem_ans  = 8'hFF;
        spurious = 1'b0;
      end else if (mem_read && resp_en && rdy && !rst) begin
        if (lat_cnt >= lat) begin
          lat_cnt = 0;
          n_bytes++;
          if (addr_q.size() == 0) begin
            check("mem_read_unexpected", {31'b0, mem_read}, 32'h0);
          end else begin
            exp_a = addr_q.pop_front();
            check("mem_addr", mem_addr, exp_a);
          end
          mem_ans  = mem_model[mem_addr[11:0]];
          mem_done = 1'b1;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int unsigned b;
    b = int'(a[11:2]) * 4;
    return {mem_model[b+3], mem_model[b+2], mem_model[b+1], mem_model[b]};
  endfunction

  task automatic fetch(input logic [31:0] a, input bit stall);
    int unsigned idx;
    int unsigned cyc;
    int unsigned b0;
    bit          hit;
    bit          done;
    bit          stalled;
    logic [31:0] base;
    logic [31:0] saved;
    idx     = int'(a[7:2]);
    base    = {a[31:2], 2'b00};
    hit     = m_valid[idx] && (m_tag[idx] == a[31:8]);
    b0      = n_bytes;
    cyc     = 0;
    done    = 1'b0;
    stalled = 1'b0;
    word_q.push_back(model_word(a));
    if (!hit) for (int unsigned i = 0; i < 4; i++) addr_q.push_back(base + i);
    ic_read = 1'b1;
    ic_addr = a;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
      if (stall && !stalled && n_bytes == b0 + 1) begin
        tick();
        cyc++;
        stalled = 1'b1;
        rdy     = 1'b0;
        resp_en = 1'b0;
        saved   = mem_addr;
        check("stall_mem_addr_entry", saved, base + 32'd1);
        for (int unsigned s = 0; s < 3; s++) begin
          tick();
          cyc++;
          check("stall_mem_addr_hold", mem_addr, saved);
          check("stall_mem_read_hold", {31'b0, mem_read}, 32'h1);
        end
        rdy     = 1'b1;
        resp_en = 1'b1;
      end
      if (ic_done) begin
        done = 1'b1;
        if (word_q.size() == 0) check("ic_done_unexpected", {31'b0, ic_done}, 32'h0);
        else check("ic_ans", ic_ans, word_q.pop_front());
      end
    end
    ic_read = 1'b0;
    if (!done) begin
      check("ic_done_timeout", {31'b0, ic_done}, 32'h1);
    end else if (hit) begin
      check("hit_latency", cyc, 32'd2);
      check("hit_mem_bytes", n_bytes - b0, 32'd0);
    end else begin
      check("miss_mem_bytes", n_bytes - b0, 32'd4);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a[31:8];
    end
    tick();
    check("ic_done_one_cycle", {31'b0, ic_done}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned b0;
    for (int unsigned i = 0; i < 4096; i++) mem_model[i] = 8'((i * 37 + 11) ^ (i >> 8));
    mem_model[0] = 8'h13;
    mem_model[1] = 8'h05;
    mem_model[2] = 8'h10;
    mem_model[3] = 8'h00;
    for (int unsigned i = 0; i < 64; i++) m_valid[i] = 1'b0;

    rst     = 1'b1;
    rdy     = 1'b1;
    ic_read = 1'b0;
    ic_addr = '0;
    tick();
    tick();
    check("rst_ic_done",  {31'b0, ic_done},  32'h0);
    check("rst_ic_ans",   ic_ans,            32'h0);
    check("rst_mem_read", {31'b0, mem_read}, 32'h0);
    check("rst_mem_addr", mem_addr,          32'h0);
    rst = 1'b0;
    tick();

    lat = 1;
    fetch(32'h0000_0000, 1'b0);
    fetch(32'h0000_0000, 1'b0);
    fetch(32'h0000_0100, 1'b0);
    fetch(32'h0000_0000, 1'b0);
    fetch(32'h0000_0004, 1'b0);
    fetch(32'h0000_0006, 1'b0);

    spurious = 1'b1;
    tick();
    tick();
    check("idle_mem_done_ignored", {31'b0, mem_read}, 32'h0);
    fetch(32'h0000_0004, 1'b0);

    fetch(32'h0000_0080, 1'b1);

    b0 = n_bytes;
    addr_q.push_back(32'h48);
    addr_q.push_back(32'h49);
    ic_read = 1'b1;
    ic_addr = 32'h0000_0048;
    for (int unsigned c = 0; c < 40 && n_bytes != b0 + 2; c++) tick();
    check("rst_fill_bytes_seen", n_bytes - b0, 32'd2);
    tick();
    check("rst_fill_mem_read_before", {31'b0, mem_read}, 32'h1);
    resp_en = 1'b0;
    rst     = 1'b1;
    ic_read = 1'b0;
    #1;
    check("rst_fill_mem_read_async", {31'b0, mem_read}, 32'h0);
    check("rst_fill_mem_addr",       mem_addr,          32'h0);
    tick();
    rst = 1'b0;
    addr_q.delete();
    word_q.delete();
    for (int unsigned i = 0; i < 64; i++) m_valid[i] = 1'b0;
    resp_en = 1'b1;
    tick();
    fetch(32'h0000_0048, 1'b0);
    fetch(32'h0000_0000, 1'b0);
    fetch(32'h0000_0048, 1'b0);

    for (int unsigned r = 0; r < 24; r++) begin
      lat = $urandom_range(0, 2);
      fetch(32'(($urandom_range(0, 15) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
